alu_control_seq: RTL and testbench

//  Decodes ALUOp/funct7/funct3 into an ALU operation code covering all of RV32I and, optionally, RV32M.

---
 rtl/alu_control_seq_pkg.sv | 65 ++++++
 rtl/alu_control_seq_if.sv | 25 ++
 rtl/alu_control_seq_decode.sv | 62 ++++++
 rtl/alu_control_seq.sv | 102 ++++++++++
 tb/tb_alu_control_seq.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_control_seq_pkg.sv
// Shared ALU control encodings, decode helpers and FSM state type for alu_control_seq.
package alu_ctrl_pkg;

  localparam int CODE_W = 5;
  typedef logic [CODE_W-1:0] code_t;

  localparam code_t OP_AND    = 5'b00000;
  localparam code_t OP_OR     = 5'b00001;
  localparam code_t OP_ADD    = 5'b00010;
  localparam code_t OP_XOR    = 5'b00011;
  localparam code_t OP_SLL    = 5'b00100;
  localparam code_t OP_SRL    = 5'b00101;
  localparam code_t OP_SUB    = 5'b00110;
  localparam code_t OP_SRA    = 5'b00111;
  localparam code_t OP_SLT    = 5'b01000;
  localparam code_t OP_SLTU   = 5'b01001;
  localparam code_t OP_MUL    = 5'b01010;
  localparam code_t OP_MULH   = 5'b01011;
  localparam code_t OP_MULHSU = 5'b01100;
  localparam code_t OP_MULHU  = 5'b01101;
  localparam code_t OP_DIV    = 5'b01110;
  localparam code_t OP_DIVU   = 5'b01111;
  localparam code_t OP_REM    = 5'b10000;
  localparam code_t OP_REMU   = 5'b10001;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MC,
    ST_HOLD
  } state_t;

  // fun3 -> op for the base (fun7=0) integer group, shared by R- and I-type
  function automatic code_t base_op(input logic [2:0] f3);
    code_t c;
    case (f3)
      3'b000:  c = OP_ADD;
      3'b001:  c = OP_SLL;
      3'b010:  c = OP_SLT;
      3'b011:  c = OP_SLTU;
      3'b100:  c = OP_XOR;
      3'b101:  c = OP_SRL;
      3'b110:  c = OP_OR;
      default: c = OP_AND;
    endcase
    return c;
  endfunction

  function automatic logic is_mul(input code_t c);
    return (c >= OP_MUL) && (c <= OP_MULHU);
  endfunction

  function automatic logic is_div(input code_t c);
    return (c >= OP_DIV) && (c <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// Handshake and decode bus between the main decoder, alu_control_seq and the datapath.
interface alu_control_seq_if #(
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [6:0]        fun7;
  logic [2:0]        fun3;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] control_out;
  logic              busy;
  logic              illegal;

  modport master (
    output in_valid, alu_op, fun7, fun3, out_ready,
    input  in_ready, out_valid, control_out, busy, illegal
  );

  modport slave (
    input  in_valid, alu_op, fun7, fun3, out_ready,
    output in_ready, out_valid, control_out, busy, illegal
  );
endinterface

// File: rtl/alu_control_seq_decode.sv
// Combinational alu_op/fun7/fun3 decode into ALU op code, illegal flag and mul/div class.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [1:0] alu_op_i,
  input  logic [6:0] fun7_i,
  input  logic [2:0] fun3_i,
  output code_t      code_o,
  output logic       illegal_o,
  output logic       is_mul_o,
  output logic       is_div_o
);

  always_comb begin
    code_o    = OP_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_LDST: code_o = OP_ADD;
      ALUOP_BRANCH: begin
        case (fun3_i[2:1])
          2'b00:   code_o = OP_SUB;
          2'b10:   code_o = OP_SLT;
          2'b11:   code_o = OP_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        if (fun7_i == F7_BASE) begin
          code_o = base_op(fun3_i);
        end else if (fun7_i == F7_ALT) begin
          if (fun3_i == 3'b000)      code_o = OP_SUB;
          else if (fun3_i == 3'b101) code_o = OP_SRA;
          else                       illegal_o = 1'b1;
        end else if ((fun7_i == F7_MULDIV) && (ENABLE_M != 0)) begin
          code_o = OP_MUL + code_t'(fun3_i);
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        // I-type: fun7 is immediate data except for the shift encodings
        if (fun3_i == 3'b001) begin
          if (fun7_i == F7_BASE) code_o = OP_SLL;
          else                   illegal_o = 1'b1;
        end else if (fun3_i == 3'b101) begin
          if (fun7_i == F7_BASE)     code_o = OP_SRL;
          else if (fun7_i == F7_ALT) code_o = OP_SRA;
          else                       illegal_o = 1'b1;
        end else begin
          code_o = base_op(fun3_i);
        end
      end
    endcase
    if (illegal_o) code_o = OP_ADD;
  end

  assign is_mul_o = is_mul(code_o);
  assign is_div_o = is_div(code_o);

endmodule

// File: rtl/alu_control_seq.sv
// ALU control stage: decode plus registered valid/ready handshake with multi-cycle MUL/DIV hold.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W   = 5,
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_control_seq_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ill_q, ill_d;

  code_t            dec_code;
  logic             dec_ill, dec_mul, dec_div;
  logic [CNT_W-1:0] lat_m1;
  logic             in_ready;
  logic             accept;

  alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .alu_op_i  (bus.alu_op),
    .fun7_i    (bus.fun7),
    .fun3_i    (bus.fun3),
    .code_o    (dec_code),
    .illegal_o (dec_ill),
    .is_mul_o  (dec_mul),
    .is_div_o  (dec_div)
  );

  always_comb begin
    lat_m1 = '0;
    if (dec_mul)      lat_m1 = CNT_W'(MUL_LAT - 1);
    else if (dec_div) lat_m1 = CNT_W'(DIV_LAT - 1);
  end

  assign in_ready = !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    if (flush) begin
      // control_out deliberately keeps its last value across a flush
      state_d = ST_IDLE;
      cnt_d   = '0;
      ill_d   = 1'b0;
    end else if (accept) begin
      ctrl_d  = CTRL_W'(dec_code);
      ill_d   = dec_ill;
      cnt_d   = lat_m1;
      state_d = (lat_m1 != '0) ? ST_MC : ST_HOLD;
    end else begin
      case (state_q)
        ST_MC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
            ill_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= CTRL_W'(OP_ADD);
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == ST_HOLD);
  assign bus.busy        = (state_q == ST_MC);
  assign bus.control_out = ctrl_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: decode table, multi-cycle corner cases, randomized run.
module tb_alu_control_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  alu_control_seq_if #(.CTRL_W(5)) b1 ();
  alu_control_seq_if #(.CTRL_W(5)) b2 ();

  alu_control_seq #(.CTRL_W(5), .ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1.slave)
  );

  alu_control_seq #(.CTRL_W(5), .ENABLE_M(0), .MUL_LAT(1), .DIV_LAT(1)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b2.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // fun3 -> code for the plain integer ops: ADD SLL SLT SLTU XOR SRL OR AND
  int base_tbl[8] = '{2, 4, 8, 9, 3, 5, 1, 0};

  function automatic void ref_dec(input int op, input int f7, input int f3,
                                  output int code, output int ill, output int lat);
    code = 2; ill = 0; lat = 1;
    case (op)
      0: code = 2;
      1: begin
        if ((f3 >> 1) == 1) ill = 1;
        else if (f3 < 2)    code = 6;
        else if (f3 < 6)    code = 8;
        else                code = 9;
      end
      2: begin
        if (f7 == 0) code = base_tbl[f3];
        else if (f7 == 'h20) begin
          if (f3 == 0)      code = 6;
          else if (f3 == 5) code = 7;
          else              ill = 1;
        end else if (f7 == 1) begin
          code = 10 + f3;
          lat  = (f3 < 4) ? 2 : 32;
        end else ill = 1;
      end
      default: begin
        if (f3 == 1)      begin if (f7 == 0) code = 4; else ill = 1; end
        else if (f3 == 5) begin
          if (f7 == 0)         code = 5;
          else if (f7 == 'h20) code = 7;
          else                 ill = 1;
        end else code = base_tbl[f3];
      end
    endcase
    if (ill != 0) begin code = 2; lat = 1; end
  endfunction

  // transaction-level model of dut: op in stage, cycle its result becomes valid
  int m_have = 0, m_done = 0, m_cyc = 0, m_code = 2, m_ill = 0;

  task automatic drive1(input int v, input int op, input int f7, input int f3, input int ordy);
    b1.in_valid  = v[0];
    b1.alu_op    = 2'(op);
    b1.fun7      = 7'(f7);
    b1.fun3      = 3'(f3);
    b1.out_ready = ordy[0];
  endtask

  task automatic step(input int v, input int op, input int f7, input int f3,
                      input int ordy, input int fl);
    int ov, bz, ir, c, il, lt;
    drive1(v, op, f7, f3, ordy);
    flush = fl[0];
    #1;
    ov = int'(m_have != 0 && m_cyc >= m_done);
    bz = int'(m_have != 0 && m_cyc < m_done);
    ir = int'(fl == 0 && (m_have == 0 || (ov != 0 && ordy != 0)));
    chk("rnd_in_ready",  int'(b1.in_ready),    ir);
    chk("rnd_out_valid", int'(b1.out_valid),   ov);
    chk("rnd_busy",      int'(b1.busy),        bz);
    chk("rnd_illegal",   int'(b1.illegal),     int'(ov != 0 && m_ill != 0));
    chk("rnd_control",   int'(b1.control_out), m_code);
    @(posedge clk);
    m_cyc++;
    ref_dec(op, f7, f3, c, il, lt);
    if (fl != 0) m_have = 0;
    else if (v != 0 && ir != 0) begin
      m_have = 1; m_done = m_cyc + lt - 1; m_code = c; m_ill = il;
    end else if (ov != 0 && ordy != 0) m_have = 0;
    #1;
  endtask

  typedef struct {
    int op, f7, f3;
    int code_m, ill_m, lat_m;
    int code_nm, ill_nm;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, n, l1, l2, c1, c2, i1, i2;

    vecs.push_back('{2, 'h20, 0,  6, 0,  1,  6, 0});
    vecs.push_back('{2, 'h01, 4, 14, 0, 32,  2, 1});
    vecs.push_back('{3, 'h20, 0,  2, 0,  1,  2, 0});
    vecs.push_back('{2, 'h00, 7,  0, 0,  1,  0, 0});
    vecs.push_back('{2, 'h01, 0, 10, 0,  2,  2, 1});
    vecs.push_back('{1, 'h33, 2,  2, 1,  1,  2, 1});
    vecs.push_back('{1, 'h00, 1,  6, 0,  1,  6, 0});
    vecs.push_back('{1, 'h00, 5,  8, 0,  1,  8, 0});
    vecs.push_back('{1, 'h00, 7,  9, 0,  1,  9, 0});
    vecs.push_back('{0, 'h7f, 7,  2, 0,  1,  2, 0});
    vecs.push_back('{3, 'h00, 1,  4, 0,  1,  4, 0});
    vecs.push_back('{3, 'h20, 1,  2, 1,  1,  2, 1});
    vecs.push_back('{3, 'h20, 5,  7, 0,  1,  7, 0});
    vecs.push_back('{3, 'h00, 5,  5, 0,  1,  5, 0});
    vecs.push_back('{3, 'h01, 5,  2, 1,  1,  2, 1});
    vecs.push_back('{2, 'h20, 3,  2, 1,  1,  2, 1});
    vecs.push_back('{2, 'h40, 0,  2, 1,  1,  2, 1});
    vecs.push_back('{2, 'h01, 7, 17, 0, 32,  2, 1});
    vecs.push_back('{2, 'h01, 3, 13, 0,  2,  2, 1});
    vecs.push_back('{3, 'h55, 4,  3, 0,  1,  3, 0});
    vecs.push_back('{3, 'h7f, 6,  1, 0,  1,  1, 0});
    vecs.push_back('{2, 'h00, 2,  8, 0,  1,  8, 0});
    vecs.push_back('{2, 'h00, 5,  5, 0,  1,  5, 0});
    vecs.push_back('{2, 'h01, 6, 16, 0, 32,  2, 1});
    vecs.push_back('{2, 'h00, 1,  4, 0,  1,  4, 0});
    vecs.push_back('{2, 'h01, 2, 12, 0,  2,  2, 1});
    vecs.push_back('{2, 'h01, 5, 15, 0, 32,  2, 1});

    drive1(0, 0, 0, 0, 0);
    b2.in_valid = 1'b0; b2.alu_op = '0; b2.fun7 = '0; b2.fun3 = '0; b2.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_control", int'(b1.control_out), 2);
    chk("rst_out_valid", int'(b1.out_valid), 0);
    chk("rst_busy", int'(b1.busy), 0);
    chk("rst_illegal", int'(b1.illegal), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(b1.in_ready), 1);
    chk("idle_control_nm", int'(b2.control_out), 2);

    // decode table on both configurations
    foreach (vecs[i]) begin
      drive1(1, vecs[i].op, vecs[i].f7, vecs[i].f3, 1);
      b2.in_valid = 1'b1; b2.alu_op = 2'(vecs[i].op); b2.fun7 = 7'(vecs[i].f7);
      b2.fun3 = 3'(vecs[i].f3); b2.out_ready = 1'b1;
      #1;
      chk("tbl_in_ready", int'(b1.in_ready), 1);
      @(posedge clk); #1;
      b1.in_valid = 1'b0; b2.in_valid = 1'b0;
      n = 1; l1 = 0; l2 = 0; c1 = -1; c2 = -1; i1 = -1; i2 = -1;
      while ((l1 == 0 || l2 == 0) && n <= 40) begin
        if (l1 == 0 && b1.out_valid) begin l1 = n; c1 = int'(b1.control_out); i1 = int'(b1.illegal); end
        if (l2 == 0 && b2.out_valid) begin l2 = n; c2 = int'(b2.control_out); i2 = int'(b2.illegal); end
        if (l1 == 0 || l2 == 0) begin @(posedge clk); #1; n++; end
      end
      chk($sformatf("tbl%0d_code", i), c1, vecs[i].code_m);
      chk($sformatf("tbl%0d_illegal", i), i1, vecs[i].ill_m);
      chk($sformatf("tbl%0d_latency", i), l1, vecs[i].lat_m);
      chk($sformatf("tbl%0d_nm_code", i), c2, vecs[i].code_nm);
      chk($sformatf("tbl%0d_nm_illegal", i), i2, vecs[i].ill_nm);
      chk($sformatf("tbl%0d_nm_latency", i), l2, 1);
      @(posedge clk); #1;
    end

    // DIV window with in_valid held high and downstream stalled, then back-to-back AND
    drive1(1, 2, 'h01, 4, 0);
    #1;
    chk("div_accept", int'(b1.in_ready), 1);
    @(posedge clk); #1;
    drive1(1, 2, 0, 7, 0);
    bad = 0;
    for (int k = 1; k <= 31; k++) begin
      if (!(b1.busy && !b1.out_valid && !b1.in_ready && b1.control_out == 5'd14)) bad++;
      @(posedge clk); #1;
    end
    chk("div_busy_bad_cycles", bad, 0);
    chk("div_out_valid", int'(b1.out_valid), 1);
    chk("div_busy_end", int'(b1.busy), 0);
    chk("div_code", int'(b1.control_out), 14);
    chk("div_stall_in_ready", int'(b1.in_ready), 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (!(b1.out_valid && !b1.busy && !b1.illegal && b1.control_out == 5'd14)) bad++;
    end
    chk("stall_frozen_bad_cycles", bad, 0);
    b1.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", int'(b1.in_ready), 1);
    @(posedge clk); #1;
    chk("b2b_out_valid", int'(b1.out_valid), 1);
    chk("b2b_code_and", int'(b1.control_out), 0);
    b1.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", int'(b1.out_valid), 0);

    // flush in cycle 10 of a DIV, with a competing request ignored
    drive1(1, 2, 'h01, 4, 1);
    @(posedge clk); #1;
    drive1(1, 2, 0, 6, 1);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("flush_in_ready", int'(b1.in_ready), 0);
    chk("flush_busy_before", int'(b1.busy), 1);
    @(posedge clk); #1;
    flush = 1'b0; b1.in_valid = 1'b0;
    #1;
    chk("flush_busy", int'(b1.busy), 0);
    chk("flush_out_valid", int'(b1.out_valid), 0);
    chk("flush_in_ready_after", int'(b1.in_ready), 1);
    chk("flush_code_retained", int'(b1.control_out), 14);
    @(posedge clk); #1;
    chk("flush_no_sample", int'(b1.out_valid), 0);

    // flush clears a pending illegal result
    drive1(1, 2, 'h40, 0, 0);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    chk("ill_flag", int'(b1.illegal), 1);
    chk("ill_code", int'(b1.control_out), 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("ill_flush_clear", int'(b1.illegal), 0);
    chk("ill_flush_valid", int'(b1.out_valid), 0);

    // asynchronous reset during MUL
    drive1(1, 2, 'h01, 0, 1);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    chk("mul_busy", int'(b1.busy), 1);
    chk("mul_code", int'(b1.control_out), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", int'(b1.control_out), 2);
    chk("arst_busy", int'(b1.busy), 0);
    chk("arst_out_valid", int'(b1.out_valid), 0);
    @(posedge clk); #1;
    chk("arst_hold_valid", int'(b1.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_after_valid", int'(b1.out_valid), 0);
    chk("arst_after_busy", int'(b1.busy), 0);

    // randomized traffic against the transaction model
    m_have = 0; m_done = 0; m_cyc = 0; m_code = 2; m_ill = 0;
    for (int t = 0; t < 600; t++) begin
      int sel, f7;
      sel = int'($urandom_range(0, 7));
      if (sel < 3)      f7 = 0;
      else if (sel < 5) f7 = 'h20;
      else if (sel < 7) f7 = 1;
      else              f7 = int'($urandom_range(0, 127));
      step(int'($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)), f7,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
